// File: rtl/i2c_addr_master_if.sv
// Request/result handshake and open-drain pad controls between the address
// translator front end and its downstream single-byte I2C master.
interface i2c_addr_master_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wr_data;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic [7:0] rd_data;

  // master: the I2C master block; slave: front end plus pad/bus side
  modport master (
    input  start, addr, rw, wr_data, sda_in,
    output scl_oe, sda_oe, busy, done, ack_error, rd_data
  );
  modport slave (
    output start, addr, rw, wr_data, sda_in,
    input  scl_oe, sda_oe, busy, done, ack_error, rd_data
  );
endinterface

// File: rtl/i2c_addr_master.sv
// Single-byte I2C master: replays START, {addr,rw}, ACK, one data byte,
// ACK/NACK and STOP on an open-drain bus, SCL rate set by DIV.
module i2c_addr_master #(
  parameter logic [15:0] DIV = 16'd250
) (
  input  logic              clk,
  input  logic              rst,
  i2c_addr_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, WRITE, READ, DACK, STOP} state_t;

  state_t      state;
  state_t      slot_next;
  logic [15:0] div_cnt;
  logic [1:0]  quarter;
  logic [2:0]  bit_idx;
  logic [7:0]  tx_sh;
  logic [7:0]  tx_next;
  logic [7:0]  wr_byte;
  logic [7:0]  rx_sh;
  logic [7:0]  rd_data;
  logic        rw_q;
  logic        sda_smp;
  logic        tick;
  logic        last_bit;
  logic        scl_oe;
  logic        sda_oe;
  logic        busy;
  logic        done;
  logic        ack_error;

  // Pad enables {scl_oe, sda_oe} for a given state, quarter and outgoing bit
  function automatic logic [1:0] drive(input state_t st, input logic [1:0] q,
                                       input logic tx_bit);
    logic scl_low;
    scl_low = (q == 2'd0) || (q == 2'd3);
    case (st)
      START:            drive = (q == 2'd0) ? 2'b00 : (q == 2'd3) ? 2'b11 : 2'b01;
      STOP:             drive = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
      ADDR, WRITE:      drive = {scl_low, ~tx_bit};
      AACK, READ, DACK: drive = {scl_low, 1'b0};
      default:          drive = 2'b00;
    endcase
  endfunction

  assign tick     = (state != IDLE) && (div_cnt == DIV - 16'd1);
  assign last_bit = (bit_idx == 3'd7);

  // Where the sequence goes when the current slot's q3 tick fires
  always_comb begin
    slot_next = state;
    tx_next   = tx_sh;
    case (state)
      START: slot_next = ADDR;
      ADDR: begin
        tx_next = {tx_sh[6:0], 1'b0};
        if (last_bit) slot_next = AACK;
      end
      AACK: begin
        if (sda_smp) begin
          slot_next = STOP;
        end else if (rw_q) begin
          slot_next = READ;
        end else begin
          slot_next = WRITE;
          tx_next   = wr_byte;
        end
      end
      WRITE: begin
        tx_next = {tx_sh[6:0], 1'b0};
        if (last_bit) slot_next = DACK;
      end
      READ:    if (last_bit) slot_next = DACK;
      DACK:    slot_next = STOP;
      STOP:    slot_next = IDLE;
      default: slot_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      quarter   <= '0;
      bit_idx   <= '0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      rd_data   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        quarter <= '0;
        bit_idx <= '0;
        if (bus.start) begin
          state     <= START;
          busy      <= 1'b1;
          tx_sh     <= {bus.addr, bus.rw};
          wr_byte   <= bus.wr_data;
          rw_q      <= bus.rw;
          ack_error <= 1'b0;
          rd_data   <= '0;
        end
      end else if (!tick) begin
        div_cnt <= div_cnt + 16'd1;
      end else begin
        div_cnt <= '0;
        if (quarter != 2'd3) begin
          quarter            <= quarter + 2'd1;
          {scl_oe, sda_oe}   <= drive(state, quarter + 2'd1, tx_sh[7]);
          // SCL has been high for a full quarter when q1 ends
          if (quarter == 2'd1) begin
            sda_smp <= bus.sda_in;
            if (state == READ) rx_sh <= {rx_sh[6:0], bus.sda_in};
          end
        end else begin
          quarter          <= 2'd0;
          state            <= slot_next;
          tx_sh            <= tx_next;
          {scl_oe, sda_oe} <= drive(slot_next, 2'd0, tx_next[7]);
          bit_idx          <= (state == slot_next) ? bit_idx + 3'd1 : 3'd0;
          if (state == AACK && sda_smp) ack_error <= 1'b1;
          if (state == DACK) begin
            if (rw_q)         rd_data   <= rx_sh;
            else if (sda_smp) ack_error <= 1'b1;
          end
          if (state == STOP) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.scl_oe    = scl_oe;
  assign bus.sda_oe    = sda_oe;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.ack_error = ack_error;
  assign bus.rd_data   = rd_data;
endmodule

// File: doc/i2c_addr_master.md
# i2c_addr_master

Single-byte I2C bus master that forms the outbound half of the address translator. It takes the transaction captured by the I2C slave front end, with the address already translated, and replays it on the downstream bus: START, 7-bit address plus R/W, one data byte, ACK handling, STOP. SCL and SDA are driven open-drain through output-enable pins. A programmable divider sets the SCL rate.

## Interface
- DIV, 250: system clocks per SCL quarter-period (16-bit, legal range 2..65535); SCL period = 4*DIV clocks.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- addr  in  7  translated target address, captured on accept.
- rw  in  1  0 = write wr_data, 1 = read one byte; captured on accept.
- wr_data  in  8  byte to write, captured on accept.
- sda_in  in  1  synchronized SDA level from the pad (two-flop sync external).
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse at transaction end.
- ack_error  out  1  1 = address or write-data NACK seen; valid at done, held until next accept.
- rd_data  out  8  byte read; valid at done when rw=1, held until next accept.

## Operation
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0, rd_data=0x00, state IDLE, divider 0, quarter 0.
- Quarter tick: divider counts 0..DIV-1 and ticks on DIV-1. The divider is held at 0 in IDLE. Each "slot" is 4 quarters q0..q3, and state/bit advances on the tick ending q3.
- States: IDLE -> START -> ADDR (8 slots, MSB first, {addr,rw}) -> AACK -> WRITE or READ (8 slots) -> DACK -> STOP -> IDLE.
- Data/ACK slot: q0 SCL low, SDA set to the bit (0 drives low, 1 releases). q1,q2 SCL released. q3 SCL low. sda_in is sampled on the tick ending q1.
- START slot: q0 both released. q1,q2 SDA low, SCL released. q3 both low.
- STOP slot: q0 SCL low, SDA low. q1 SCL released, SDA low. q2,q3 both released.
- AACK: master releases SDA. If the sample is 1 (NACK), set ack_error and go directly to STOP.
- WRITE: DACK releases SDA. A sample of 1 sets ack_error. STOP follows in either case.
- READ: SDA released for 8 slots; samples shift into a register MSB first. DACK drives NACK (SDA released), which ends the single-byte read. rd_data updates at the end of DACK.
- done pulses the cycle after the STOP final tick, with busy falling in the same cycle. Accept on the done cycle is legal only if busy=0. A start asserted while busy is ignored and is not queued.
- No clock stretching and no arbitration: SCL is never read back.
- Reset mid-transaction: next clock returns to IDLE, both OE=0, outputs go to reset values, and no done pulse. The bus may be left mid-frame; recovery is the system's responsibility.

## Timing
- Accept: start=1 with busy=0 at edge N gives busy=1 at N+1, and the START q0 begins at N+1.
- Full write or read transaction: 20 slots = 80*DIV clocks from accept to the STOP final tick. done=1 at accept+80*DIV+1.
- Address NACK: 11 slots (START, 8 addr, AACK, STOP). done at accept+44*DIV+1.
- OE outputs are registered and change only on tick edges.

## Test plan
- DIV=4, write addr=0x50 wr_data=0xA5, bus model ACKs both bytes -> SDA bit stream 0xA0 then 0xA5 at SCL rising edges. done at accept+321. ack_error=0.
- DIV=4, write addr=0x12, model NACKs address -> STOP immediately after AACK. done at accept+177. ack_error=1. No data bits driven.
- DIV=4, read addr=0x2C, model ACKs then returns 0x3C -> address byte 0x59. Master releases SDA in DACK (NACK). rd_data=0x3C, ack_error=0 at done.
- Write with data NACK on 0x77 -> ack_error=1, normal STOP, done at accept+321.
- start pulsed mid-transaction and on the cycle after done -> mid-transaction start ignored with no timing change. Start after done is accepted, and a new START is generated with fresh addr/rw/wr_data captured.
- rst asserted during the 5th address bit -> next cycle scl_oe=sda_oe=0, busy=0, no done pulse. A subsequent write completes normally.
